obstacle_spawn_sched: RTL and testbench

OBSTACLE_SPAWN_SCHED -- requirements
Module: obstacle_spawn_sched

---
 rtl/obstacle_spawn_sched_pkg.sv | 33 +++
 rtl/spawn_lfsr4.sv | 24 ++
 rtl/obstacle_spawn_sched.sv | 99 +++++++++
 tb/tb_obstacle_spawn_sched.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_spawn_sched_pkg.sv
// Shared definitions for the obstacle spawn scheduler.
//   state_e     : scheduler FSM states
//   obs_type_e  : obstacle kind codes driven on spawn_type
//   LfsrSeed    : LFSR value after reset
//   lfsr_next() : one step of the 4-bit spawn LFSR
package obstacle_spawn_sched_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StLoad  = 2'b01,
        StCount = 2'b10,
        StReq   = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        ObsSmallCactus = 2'b00,
        ObsLargeCactus = 2'b01,
        ObsBird        = 2'b10,
        ObsCactusPair  = 2'b11
    } obs_type_e;

    localparam logic [3:0] LfsrSeed = 4'b0000;

    // Right shift, XNOR feedback into bit 3. All-ones is the lock-up state of an
    // XNOR LFSR, so it is steered back onto the 15-state cycle.
    function automatic logic [3:0] lfsr_next(input logic [3:0] s);
        if (s == 4'b1111) begin
            return 4'b0000;
        end
        return {~(s[1] ^ s[0]), s[3:1]};
    endfunction

endpackage

// File: rtl/spawn_lfsr4.sv
// 4-bit pseudo-random source for obstacle gaps and types.
// Ports:
//   clk   : system clock
//   reset : synchronous active-low reset (loads LfsrSeed)
//   step  : advance one state this cycle; hold otherwise
//   q     : current LFSR state
module spawn_lfsr4
    import obstacle_spawn_sched_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    output logic [3:0] q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= LfsrSeed;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/obstacle_spawn_sched.sv
// Obstacle spawn scheduler: picks a pseudo-random gap (in game ticks) and
// obstacle type, counts the gap down, then raises a held spawn request until
// the renderer acknowledges it.
// Ports:
//   clk         : system clock
//   reset       : synchronous active-low reset
//   en          : game running; low forces idle
//   tick        : one-cycle game-frame pulse, countdown time base
//   speed       : difficulty, right-shift applied to the raw gap
//   spawn_req   : spawn request, held until spawn_ack
//   spawn_ack   : renderer accepts the request
//   spawn_type  : obstacle kind, stable while spawn_req is high
//   gap         : ticks remaining in the current countdown
//   spawn_count : accepted spawns, wrapping
module obstacle_spawn_sched
    import obstacle_spawn_sched_pkg::*;
#(
    parameter int unsigned MIN_GAP = 15,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             tick,
    input  logic [1:0]       speed,
    output logic             spawn_req,
    input  logic             spawn_ack,
    output logic [1:0]       spawn_type,
    output logic [7:0]       gap,
    output logic [CNT_W-1:0] spawn_count
);

    localparam logic [7:0] MinGap = 8'(MIN_GAP);

    state_e     state;
    logic [3:0] s;
    logic       step;
    logic [7:0] raw;
    logic [7:0] shifted;
    logic [7:0] load_gap;

    // The LFSR only moves in a LOAD cycle that actually completes; en low wins.
    assign step     = en && (state == StLoad);
    assign raw      = {s, 4'b1111};
    assign shifted  = raw >> speed;
    assign load_gap = (shifted < MinGap) ? MinGap : shifted;

    spawn_lfsr4 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (step),
        .q     (s)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= StIdle;
            spawn_req   <= 1'b0;
            spawn_type  <= 2'b00;
            gap         <= 8'd0;
            spawn_count <= '0;
        end else if (!en) begin
            // spawn_type and spawn_count deliberately hold across a pause.
            state     <= StIdle;
            spawn_req <= 1'b0;
            gap       <= 8'd0;
        end else begin
            unique case (state)
                StIdle: begin
                    state <= StLoad;
                end
                StLoad: begin
                    gap        <= load_gap;
                    spawn_type <= s[1:0];
                    state      <= StCount;
                end
                StCount: begin
                    if (gap == 8'd0) begin
                        state     <= StReq;
                        spawn_req <= 1'b1;
                    end else if (tick) begin
                        gap <= gap - 8'd1;
                    end
                end
                StReq: begin
                    if (spawn_ack) begin
                        state       <= StLoad;
                        spawn_req   <= 1'b0;
                        spawn_count <= spawn_count + 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_obstacle_spawn_sched.sv
module tb_obstacle_spawn_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       tick;
    logic [1:0] speed;
    logic       spawn_req;
    logic       spawn_ack;
    logic [1:0] spawn_type;
    logic [7:0] gap;
    logic [7:0] spawn_count;

    int n_cmp = 0;
    int n_err = 0;

    // Hand-derived LFSR walk from 0000: 0,8,C,E,7,B,D,6,3,9,4,A,5,2,1.
    // Gap at speed 0 is {s,F}; type is s[1:0].
    logic [7:0] gap_tab [15] = '{8'h0F, 8'h8F, 8'hCF, 8'hEF, 8'h7F, 8'hBF, 8'hDF, 8'h6F,
                                 8'h3F, 8'h9F, 8'h4F, 8'hAF, 8'h5F, 8'h2F, 8'h1F};
    logic [1:0] typ_tab [15] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd3, 2'd3, 2'd1, 2'd2,
                                 2'd3, 2'd1, 2'd0, 2'd2, 2'd1, 2'd2, 2'd1};

    obstacle_spawn_sched dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .tick        (tick),
        .speed       (speed),
        .spawn_req   (spawn_req),
        .spawn_ack   (spawn_ack),
        .spawn_type  (spawn_type),
        .gap         (gap),
        .spawn_count (spawn_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reset, then raise en; returns with the DUT in LOAD.
    task automatic restart(input logic [1:0] spd);
        reset = 1'b0; en = 1'b0; tick = 1'b0; spawn_ack = 1'b0; speed = spd;
        cyc(); cyc();
        reset = 1'b1; en = 1'b1;
        cyc();
    endtask

    // From LOAD: one edge into COUNT, check the loaded gap and type.
    task automatic load_check(input logic [7:0] eg, input logic [1:0] et, input string nm);
        cyc();
        n_cmp++;
        if (gap !== eg) begin
            n_err++; $display("FAIL %s gap: got %0d, required %0d", nm, gap, eg);
        end
        n_cmp++;
        if (spawn_type !== et) begin
            n_err++; $display("FAIL %s type: got %0d, required %0d", nm, spawn_type, et);
        end
    endtask

    // Tick n times, confirm gap reaches 0 without req, then req rises one cycle later.
    task automatic countdown(input int n, input string nm);
        tick = 1'b1;
        repeat (n) cyc();
        tick = 1'b0;
        n_cmp++;
        if (gap !== 8'd0 || spawn_req !== 1'b0) begin
            n_err++;
            $display("FAIL %s at zero: got gap=%0d req=%b, required gap=0 req=0", nm, gap,
                     spawn_req);
        end
        cyc();
        n_cmp++;
        if (spawn_req !== 1'b1) begin
            n_err++; $display("FAIL %s req rise: got %b, required 1", nm, spawn_req);
        end
    endtask

    // Ack for one cycle; returns in LOAD.
    task automatic ack_once(input logic [7:0] ecnt, input string nm);
        spawn_ack = 1'b1;
        cyc();
        spawn_ack = 1'b0;
        n_cmp++;
        if (spawn_count !== ecnt || spawn_req !== 1'b0) begin
            n_err++;
            $display("FAIL %s transfer: got count=%0d req=%b, required count=%0d req=0", nm,
                     spawn_count, spawn_req, ecnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b1; tick = 1'b1; spawn_ack = 1'b1; speed = 2'd0;
        cyc(); cyc();
        n_cmp++;
        if (spawn_req !== 1'b0 || gap !== 8'd0 || spawn_type !== 2'd0 || spawn_count !== 8'd0)
        begin
            n_err++;
            $display("FAIL reset state: got req=%b gap=%0d type=%0d cnt=%0d, required all 0",
                     spawn_req, gap, spawn_type, spawn_count);
        end
    endtask

    task automatic test_full_period();
        restart(2'd0);
        for (int i = 0; i < 16; i++) begin
            load_check(gap_tab[i % 15], typ_tab[i % 15], $sformatf("period[%0d]", i));
            countdown(int'(gap_tab[i % 15]), $sformatf("period[%0d]", i));
            ack_once(8'(i + 1), $sformatf("period[%0d]", i));
        end
    endtask

    task automatic test_speed();
        restart(2'd2);
        load_check(8'd15, 2'd0, "spd2 load1 clamp");
        countdown(15, "spd2 load1");
        ack_once(8'd1, "spd2 load1");
        load_check(8'd35, 2'd0, "spd2 load2");
        countdown(35, "spd2 load2");
        ack_once(8'd2, "spd2 load2");
        load_check(8'd51, 2'd0, "spd2 load3");
        countdown(51, "spd2 load3");
        ack_once(8'd3, "spd2 load3");
        // 0xEF >> 3 = 29; changing speed mid-count must not reload.
        speed = 2'd3;
        load_check(8'd29, 2'd2, "spd3 load4");
        speed = 2'd0;
        tick = 1'b1;
        repeat (5) cyc();
        tick = 1'b0;
        cyc();
        n_cmp++;
        if (gap !== 8'd24) begin
            n_err++; $display("FAIL speed change mid-count: got %0d, required 24", gap);
        end
        restart(2'd3);
        load_check(8'd15, 2'd0, "spd3 first clamp");
    endtask

    task automatic test_stall();
        restart(2'd0);
        load_check(8'd15, 2'd0, "stall load");
        countdown(15, "stall");
        for (int i = 0; i < 20; i++) begin
            tick = ~tick;
            cyc();
            n_cmp++;
            if (spawn_req !== 1'b1 || spawn_type !== 2'd0 || gap !== 8'd0) begin
                n_err++;
                $display("FAIL stall[%0d]: got req=%b type=%0d gap=%0d, required 1/0/0", i,
                         spawn_req, spawn_type, gap);
            end
        end
        tick = 1'b0;
        ack_once(8'd1, "stall");
        // Ack held on while no request is pending must be ignored.
        spawn_ack = 1'b1;
        cyc();
        n_cmp++;
        if (gap !== 8'd143) begin
            n_err++; $display("FAIL stall next gap: got %0d, required 143", gap);
        end
        cyc();
        spawn_ack = 1'b0;
        n_cmp++;
        if (spawn_count !== 8'd1) begin
            n_err++; $display("FAIL stray ack count: got %0d, required 1", spawn_count);
        end
    endtask

    task automatic test_en_drop();
        restart(2'd0);
        load_check(8'd15, 2'd0, "endrop load");
        tick = 1'b1;
        repeat (8) cyc();
        n_cmp++;
        if (gap !== 8'd7) begin
            n_err++; $display("FAIL endrop pre gap: got %0d, required 7", gap);
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++;
            if (gap !== 8'd0 || spawn_req !== 1'b0 || spawn_type !== 2'd0) begin
                n_err++;
                $display("FAIL endrop idle[%0d]: got gap=%0d req=%b type=%0d, required 0/0/0",
                         i, gap, spawn_req, spawn_type);
            end
        end
        tick = 1'b0;
        en = 1'b1;
        cyc();
        load_check(8'd143, 2'd0, "endrop resume");
        n_cmp++;
        if (spawn_count !== 8'd0) begin
            n_err++; $display("FAIL endrop count: got %0d, required 0", spawn_count);
        end
    endtask

    task automatic test_reset_in_req();
        restart(2'd0);
        load_check(8'd15, 2'd0, "rstreq load");
        countdown(15, "rstreq");
        reset = 1'b0;
        spawn_ack = 1'b1;
        cyc();
        n_cmp++;
        if (spawn_count !== 8'd0 || spawn_req !== 1'b0 || gap !== 8'd0) begin
            n_err++;
            $display("FAIL reset in req: got cnt=%0d req=%b gap=%0d, required 0/0/0",
                     spawn_count, spawn_req, gap);
        end
        reset = 1'b1;
        spawn_ack = 1'b0;
        cyc();
        load_check(8'd15, 2'd0, "rstreq restart");
    endtask

    initial begin
        test_reset();
        test_full_period();
        test_speed();
        test_stall();
        test_en_drop();
        test_reset_in_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
